// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared states, segment codes and BCD helpers for countdown_timer_2d
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Active-low segment patterns, bit order a..g MSB-first
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Saturate a loaded digit so the counter never holds a non-BCD value
    function automatic logic [3:0] bcd_clamp(input logic [3:0] value, input logic [3:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/countdown_timer_2d_bcd_to_seg7.sv
// rtl/countdown_timer_2d_bcd_to_seg7.sv - combinational BCD to active-low 7-segment decoder
module bcd_to_seg7
    import countdown_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Non-BCD codes blank the digit rather than show garbage
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_timer_2d.sv
// rtl/countdown_timer_2d.sv - two-digit BCD countdown timer with 7-segment outputs (optional COUNTDOWN_BLINK_EN)
module countdown_timer_2d
    import countdown_pkg::*;
#(
    parameter int DIV_COUNT = 50000000,
    parameter int MAX_TENS  = 9
) (
    input  logic       G_CLOCK_50,
    input  logic       V_RST,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_units,
    input  logic       start_stop,
    output logic [6:0] G_HEX1,
    output logic [6:0] G_HEX2,
    output logic       running,
    output logic       done
);

    localparam int         PW       = $clog2(DIV_COUNT);
    localparam logic [PW-1:0] TICK_AT = PW'(DIV_COUNT - 1);
    localparam logic [3:0] TENS_LIM = (MAX_TENS > 9) ? BCD_MAX : 4'(MAX_TENS);

    state_t        state_q, state_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    units_q, units_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          start_q;
    logic [6:0]    hex1_q, hex2_q;
    logic          running_q, done_q;
    logic [6:0]    seg_units, seg_tens;
    logic          start_edge;
    logic          tick;
    logic          at_zero;
    logic          dec_to_zero;
    logic          blank;

`ifdef COUNTDOWN_BLINK_EN
    logic blank_q, blank_d;
    assign blank = blank_q;
`else
    assign blank = 1'b0;
`endif

    assign start_edge  = start_stop & ~start_q;
    assign tick        = (presc_q == TICK_AT);
    assign at_zero     = (tens_q == 4'd0) && (units_q == 4'd0);
    assign dec_to_zero = (tens_q == 4'd0) && (units_q == 4'd1);

    bcd_to_seg7 u_seg_units (
        .bcd_i (units_q),
        .seg_o (seg_units)
    );

    bcd_to_seg7 u_seg_tens (
        .bcd_i (tens_q),
        .seg_o (seg_tens)
    );

    // Next-state: load beats everything, then per-state run/pause/decrement control
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        units_d = units_q;
        presc_d = presc_q;
`ifdef COUNTDOWN_BLINK_EN
        blank_d = blank_q;
`endif
        if (load) begin
            state_d = IDLE;
            tens_d  = bcd_clamp(load_tens, TENS_LIM);
            units_d = bcd_clamp(load_units, BCD_MAX);
            presc_d = '0;
`ifdef COUNTDOWN_BLINK_EN
            blank_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_edge && !at_zero) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (units_q != 4'd0) begin
                            units_d = units_q - 4'd1;
                        end else begin
                            units_d = BCD_MAX;
                            tens_d  = tens_q - 4'd1;
                        end
                    end
                    if (tick && dec_to_zero) begin
                        state_d = DONE;
`ifdef COUNTDOWN_BLINK_EN
                        blank_d = 1'b0;
`endif
                    end else if (start_edge) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start_edge) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
`ifdef COUNTDOWN_BLINK_EN
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        blank_d = ~blank_q;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, digits, prescaler and registered outputs
    always_ff @(posedge G_CLOCK_50) begin
        if (V_RST) begin
            state_q   <= IDLE;
            tens_q    <= 4'd0;
            units_q   <= 4'd0;
            presc_q   <= '0;
            start_q   <= 1'b0;
            hex1_q    <= SEG_0;
            hex2_q    <= SEG_0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef COUNTDOWN_BLINK_EN
            blank_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            units_q   <= units_d;
            presc_q   <= presc_d;
            start_q   <= start_stop;
            hex1_q    <= blank ? SEG_BLANK : seg_units;
            hex2_q    <= blank ? SEG_BLANK : seg_tens;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
`ifdef COUNTDOWN_BLINK_EN
            blank_q   <= blank_d;
`endif
        end
    end

    assign G_HEX1  = hex1_q;
    assign G_HEX2  = hex2_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer_2d.sv
// tb/tb_countdown_timer_2d.sv - directed scoreboard bench for countdown_timer_2d
module tb_countdown_timer_2d;

`ifdef COUNTDOWN_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    localparam logic [15:0] M_ALL   = 16'hFFFF;
    localparam logic [15:0] M_FLAGS = 16'hC000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_tens = 4'd0;
    logic [3:0] load_units = 4'd0;
    logic       start_stop = 1'b0;
    logic [6:0] hex1, hex2;
    logic       running, done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] exp;
        logic [15:0] mask;
    } exp_t;

    exp_t sb[$];

    countdown_timer_2d #(.DIV_COUNT(4), .MAX_TENS(9)) dut (
        .G_CLOCK_50 (clk),
        .V_RST      (rst),
        .load       (load),
        .load_tens  (load_tens),
        .load_units (load_units),
        .start_stop (start_stop),
        .G_HEX1     (hex1),
        .G_HEX2     (hex2),
        .running    (running),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [15:0] disp(input bit r, input bit d, input int tens, input int units);
        return {r, d, seg(tens), seg(units)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [15:0] e, input logic [15:0] m);
        sb.push_back('{tag, e, m});
    endtask

    task automatic compare_front();
        exp_t        x;
        logic [15:0] obs;
        obs = {running, done, hex2, hex1};
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
        end else begin
            x = sb.pop_front();
            assert ((obs & x.mask) === (x.exp & x.mask))
            else begin
                n_errors++;
                $error("FAIL %s observed=%h expected=%h mask=%h", x.tag, obs, x.exp, x.mask);
            end
        end
    endtask

    initial begin
        logic [15:0] bexp;

        // Reset then idle
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        expect_val("reset_idle", disp(0, 0, 0, 0), M_ALL);
        cyc(10);
        compare_front();

        // Load 12 and run to 00
        load = 1'b1; load_tens = 4'd1; load_units = 4'd2;
        cyc(1);
        load = 1'b0; start_stop = 1'b1;
        expect_val("run_start_12", disp(1, 0, 1, 2), M_ALL);
        cyc(1);
        compare_front();
        start_stop = 1'b0;
        expect_val("tick_11", disp(1, 0, 1, 1), M_ALL);
        cyc(5);
        compare_front();
        expect_val("tick_10", disp(1, 0, 1, 0), M_ALL);
        cyc(4);
        compare_front();
        expect_val("tick_09", disp(1, 0, 0, 9), M_ALL);
        cyc(4);
        compare_front();
        expect_val("tick_01", disp(1, 0, 0, 1), M_ALL);
        cyc(32);
        compare_front();
        expect_val("reach_done", disp(0, 1, 0, 0), M_ALL);
        cyc(4);
        compare_front();
        for (int i = 2; i <= 8; i++) begin
            if (BLINK && i >= 5) bexp = {2'b01, 7'b1111111, 7'b1111111};
            else                 bexp = disp(0, 1, 0, 0);
            expect_val($sformatf("done_display_%0d", i), bexp, M_ALL);
            cyc(1);
            compare_front();
        end

        // Start edge in DONE is ignored
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        expect_val("done_ignores_edge", {2'b01, 14'd0}, M_FLAGS);
        cyc(6);
        compare_front();

        // Load 00 with simultaneous edge, then a separate edge on 00
        load = 1'b1; load_tens = 4'd0; load_units = 4'd0; start_stop = 1'b1;
        cyc(1);
        load = 1'b0;
        expect_val("load00_with_edge", disp(0, 0, 0, 0), M_ALL);
        cyc(2);
        compare_front();
        start_stop = 1'b0;
        cyc(1);
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        expect_val("edge_on_00_ignored", disp(0, 0, 0, 0), M_ALL);
        cyc(3);
        compare_front();

        // Clamp 15/15 to 99
        load = 1'b1; load_tens = 4'd15; load_units = 4'd15;
        cyc(1);
        load = 1'b0;
        expect_val("clamp_99", disp(0, 0, 9, 9), M_ALL);
        cyc(1);
        compare_front();

        // Pause mid-period from 05, then resume
        load = 1'b1; load_tens = 4'd0; load_units = 4'd5;
        cyc(1);
        load = 1'b0; start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        cyc(2);
        start_stop = 1'b1;
        expect_val("pause_entry", disp(0, 0, 0, 5), M_ALL);
        cyc(1);
        compare_front();
        start_stop = 1'b0;
        expect_val("pause_frozen", disp(0, 0, 0, 5), M_ALL);
        cyc(20);
        compare_front();
        start_stop = 1'b1;
        expect_val("resume", disp(1, 0, 0, 5), M_ALL);
        cyc(1);
        compare_front();
        start_stop = 1'b0;
        expect_val("resume_pre_tick", disp(1, 0, 0, 5), M_ALL);
        cyc(1);
        compare_front();
        expect_val("resume_first_tick", disp(1, 0, 0, 4), M_ALL);
        cyc(1);
        compare_front();
        expect_val("full_period_hold", disp(1, 0, 0, 4), M_ALL);
        cyc(3);
        compare_front();
        expect_val("full_period_tick", disp(1, 0, 0, 3), M_ALL);
        cyc(1);
        compare_front();

        // Load beats a simultaneous start edge while running
        load = 1'b1; load_tens = 4'd3; load_units = 4'd7; start_stop = 1'b1;
        cyc(1);
        load = 1'b0;
        expect_val("load_beats_edge", disp(0, 0, 3, 7), M_ALL);
        cyc(1);
        compare_front();
        start_stop = 1'b0;
        expect_val("load_no_run", disp(0, 0, 3, 7), M_ALL);
        cyc(6);
        compare_front();

        // Reset while running
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        expect_val("running_before_reset", disp(1, 0, 3, 7), M_ALL);
        cyc(1);
        compare_front();
        rst = 1'b1;
        expect_val("reset_in_run", disp(0, 0, 0, 0), M_ALL);
        cyc(1);
        rst = 1'b0;
        compare_front();
        expect_val("reset_stays_idle", disp(0, 0, 0, 0), M_ALL);
        cyc(8);
        compare_front();

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer_2d.md
Name: countdown_timer_2d

Overview:
- Two-digit BCD countdown timer (99..00), the down-counting counterpart of the board's free-running 0-9 up-counter display.
- Value is loaded from the switches and decremented once per prescaled tick, with start/pause control.
- Drives two active-low 7-segment digits and asserts a done flag at 00.
- Sits at board top level; runs from the 50 MHz clock.

Parameters:
- DIV_COUNT, 50000000, clock cycles per decrement tick (tick period exactly DIV_COUNT cycles; minimum 2).
- MAX_TENS, 9, largest accepted tens digit on load; larger values are clamped to it.

Ports:
- G_CLOCK_50  input  1  system clock; all logic on rising edge.
- V_RST  input  1  synchronous, active-high reset.
- load  input  1  level; when high, captures load_tens/load_units.
- load_tens  input  4  BCD tens value to load.
- load_units  input  4  BCD units value to load.
- start_stop  input  1  level input; each rising edge toggles run/pause.
- G_HEX1  output  7  units digit, active-low segments, bit order a..g MSB-first.
- G_HEX2  output  7  tens digit, same encoding.
- running  output  1  high while in RUN.
- done  output  1  high while in DONE.

Behaviour:
- Reset (V_RST=1 at a clock edge):
  - State IDLE; digits 0/0; prescaler 0; edge-detect register 0.
  - done=0, running=0.
  - G_HEX1=G_HEX2=7'b0000001 ("0") from the first cycle after reset.
  - Reset overrides every other input.
- States: IDLE, RUN, PAUSE, DONE.
- Start edge: start_stop sampled into a register; edge = start_stop & ~prev. Edge detection is 1 cycle late relative to the input.
- Load (any state):
  - Digits take the inputs next cycle.
  - Digit value >9 is clamped to 9 (tens clamped to MAX_TENS).
  - Prescaler cleared; state becomes IDLE; done cleared.
  - Load has priority over a simultaneous start edge, which is discarded.
- IDLE:
  - Edge with digits != 00 -> RUN.
  - Edge with digits == 00 is ignored and state stays IDLE.
- RUN:
  - Prescaler increments each cycle.
  - At DIV_COUNT-1, tick=1 and the prescaler returns to 0.
  - On tick: if units != 0 then units-1; else units=9 and tens-1.
  - If the decrement result is 00 -> DONE in the same update.
  - Edge with no tick -> PAUSE.
  - Edge coincident with a tick: the decrement is applied, then -> PAUSE (or DONE if the result is 00; DONE wins).
- PAUSE:
  - Prescaler and digits hold.
  - Edge -> RUN, with the prescaler resuming from its held value.
- DONE:
  - Digits hold 00; done=1.
  - Start edges are ignored; only load or reset leave DONE.
- Segment outputs:
  - Registered, updating 1 cycle after the digit registers change.
  - Active-low encoding: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; any other value = 1111111.
- running and done are registered and match the state.
- Digit arithmetic is pure BCD and never produces A-F. Underflow below 00 is impossible because DONE is entered at 00.

Optional Feature:
- Macro: COUNTDOWN_BLINK_EN.
- Defined:
  - In DONE, the prescaler keeps running.
  - Each tick toggles a blank flag; while the flag is set, both HEX outputs are 1111111, otherwise they show "00".
  - The flag is cleared on load, reset, and entry to DONE, so the display shows "00" for the first full tick period.
- Undefined:
  - Prescaler is idle in DONE and the display is steady "00".
  - No blank flag register exists.

Decomposition:
- Package countdown_pkg:
  - State enum (IDLE, RUN, PAUSE, DONE).
  - SEG_0..SEG_9 and SEG_BLANK 7-bit constants.
  - BCD_MAX = 4'd9.
- Sub-module bcd_to_seg7: combinational 4-bit to 7-bit active-low decoder, instantiated twice (units, tens).
- Output registers stay in the parent.

Test Plan (DIV_COUNT=4):
- Reset then idle 10 cycles -> G_HEX1=G_HEX2=0000001, done=0, running=0.
- Load 1/2, start edge -> running=1; digits 12,11,10,09 at successive 4-cycle ticks; at 01 then tick -> 00, done=1, running=0, further edges ignored.
- Load 0/0 plus start edge -> stays IDLE, running=0, done=0. Load 15/15 -> digits clamp to 99.
- Run from 05, edge mid-period -> PAUSE, digits and prescaler frozen 20 cycles; second edge -> first tick after exactly the remaining prescaler cycles.
- Load asserted in the same cycle as a start edge while in RUN -> new value loaded, state IDLE, no run. V_RST asserted in RUN -> 00 and IDLE next cycle.
- With COUNTDOWN_BLINK_EN: reach DONE -> HEX shows 0000001 for 4 cycles, then 1111111 for 4 cycles, alternating. Without the macro: steady 0000001.
